// File: rtl/mean_packer_if.sv
// Sample stream and packed-vector output bundle for mean_packer.
// The slave modport is the packer; the master modport is the sample source / vector consumer.
interface mean_packer_if #(
  parameter int BUS_WIDTH  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data [0:BUS_WIDTH-1];
  logic                  o_drop;
  logic [CNT_WIDTH-1:0]  o_vec_cnt;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, o_valid, o_data, o_drop, o_vec_cnt
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, o_valid, o_data, o_drop, o_vec_cnt
  );
endinterface

// File: rtl/mean_packer.sv
// Serial-to-parallel packer: collects BUS_WIDTH samples into one lane vector for the mean stage,
// emitting it with a one-cycle o_valid pulse; bursts that end early are dropped and flagged.
module mean_packer #(
  parameter int BUS_WIDTH  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  mean_packer_if.slave   bus
);
  localparam int IDX_W = $clog2(BUS_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUS_WIDTH - 1);

  typedef enum logic {EMPTY, FILL} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] asm_q [0:BUS_WIDTH-1];
  logic [DATA_WIDTH-1:0] asm_d [0:BUS_WIDTH-1];
  logic [DATA_WIDTH-1:0] o_data_q [0:BUS_WIDTH-1];
  logic [DATA_WIDTH-1:0] o_data_d [0:BUS_WIDTH-1];
  logic                  o_valid_q, o_valid_d;
  logic                  o_drop_q, o_drop_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept;

  assign bus.s_ready = en;
  assign accept      = bus.s_valid & en;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    o_drop_d  = 1'b0;
    cnt_d     = cnt_q;
    if (accept) begin
      if (state_q == FILL && idx_q == LAST_IDX) begin
        // final lane bypasses asm so the vector is complete on this edge
        o_data_d                = asm_q;
        o_data_d[BUS_WIDTH - 1] = bus.s_data;
        o_valid_d               = 1'b1;
        cnt_d                   = cnt_q + 1'b1;
        idx_d                   = '0;
        state_d                 = EMPTY;
      end else if (bus.s_last) begin
        o_drop_d = 1'b1;
        idx_d    = '0;
        state_d  = EMPTY;
      end else begin
        asm_d[idx_q] = bus.s_data;
        idx_d        = idx_q + 1'b1;
        state_d      = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      idx_q     <= '0;
      asm_q     <= '{default: '0};
      o_data_q  <= '{default: '0};
      o_valid_q <= 1'b0;
      o_drop_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_drop_q  <= o_drop_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_drop    = o_drop_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_vec_cnt = cnt_q;
endmodule

// File: tb/tb_mean_packer.sv
// Directed bench for mean_packer: a 2-lane instance driven from a vector table and a
// 4-lane instance with a 4-bit counter driven by hand-written sequences.
module tb_mean_packer;
  logic clk = 1'b0;
  logic rst;
  logic en;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mean_packer_if #(.BUS_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(16)) if2 ();
  mean_packer_if #(.BUS_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(4))  if4 ();

  mean_packer #(.BUS_WIDTH(2), .DATA_WIDTH(8), .CNT_WIDTH(16)) u2 (
    .clk(clk), .rst(rst), .en(en), .bus(if2)
  );
  mean_packer #(.BUS_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .bus(if4)
  );

  typedef struct {
    logic       v;
    logic       last;
    logic [7:0] d;
    logic       ev;
    logic       ed;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic l, input logic [7:0] d,
                              input logic ev, input logic ed, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [15:0] c);
    vec_t r;
    r.v = v; r.last = l; r.d = d; r.ev = ev; r.ed = ed; r.e0 = e0; r.e1 = e1; r.ecnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    chk({name, ".lane0"}, {24'h0, if4.o_data[0]}, {24'h0, a});
    chk({name, ".lane1"}, {24'h0, if4.o_data[1]}, {24'h0, b});
    chk({name, ".lane2"}, {24'h0, if4.o_data[2]}, {24'h0, c});
    chk({name, ".lane3"}, {24'h0, if4.o_data[3]}, {24'h0, d});
  endtask

  task automatic drive2(input logic v, input logic l, input logic [7:0] d);
    if2.s_valid = v; if2.s_last = l; if2.s_data = d;
  endtask

  task automatic drive4(input logic v, input logic l, input logic [7:0] d);
    if4.s_valid = v; if4.s_last = l; if4.s_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 2-lane table: stream, gapped input, lane-0 drop, s_last on the final lane
    tbl.push_back(mk(1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 8'h10, 8'h20, 16'd1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 8'h10, 8'h20, 16'd1));
    tbl.push_back(mk(1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 8'h30, 8'h40, 16'd2));
    tbl.push_back(mk(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h30, 8'h40, 16'd2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 8'h40, 16'd2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 8'h40, 16'd2));
    tbl.push_back(mk(1'b1, 1'b0, 8'hBB, 1'b1, 1'b0, 8'hAA, 8'hBB, 16'd3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 8'hBB, 16'd3));
    tbl.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'hAA, 8'hBB, 16'd3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 8'hBB, 16'd3));
    tbl.push_back(mk(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 8'hAA, 8'hBB, 16'd3));
    tbl.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h66, 8'h77, 16'd4));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 8'h77, 16'd4));

    rst = 1'b0;
    en  = 1'b1;
    drive2(1'b0, 1'b0, 8'h00);
    drive4(1'b0, 1'b0, 8'h00);
    #12;
    chk("rst.valid2", {31'h0, if2.o_valid}, 32'h0);
    chk("rst.drop2",  {31'h0, if2.o_drop}, 32'h0);
    chk("rst.cnt2",   {16'h0, if2.o_vec_cnt}, 32'h0);
    chk("rst.data2",  {16'h0, if2.o_data[0], if2.o_data[1]}, 32'h0);
    chk("rst.ready2", {31'h0, if2.s_ready}, 32'h1);
    chk("rst.cnt4",   {28'h0, if4.o_vec_cnt}, 32'h0);
    chk4("rst.data4", 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive2(tbl[i].v, tbl[i].last, tbl[i].d);
      tick();
      chk($sformatf("t%0d.valid", i), {31'h0, if2.o_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("t%0d.drop", i),  {31'h0, if2.o_drop},  {31'h0, tbl[i].ed});
      chk($sformatf("t%0d.lane0", i), {24'h0, if2.o_data[0]}, {24'h0, tbl[i].e0});
      chk($sformatf("t%0d.lane1", i), {24'h0, if2.o_data[1]}, {24'h0, tbl[i].e1});
      chk($sformatf("t%0d.cnt", i),   {16'h0, if2.o_vec_cnt}, {16'h0, tbl[i].ecnt});
    end
    drive2(1'b0, 1'b0, 8'h00);

    // partial burst on the 4-lane instance
    drive4(1'b1, 1'b0, 8'hA1); tick();
    drive4(1'b1, 1'b0, 8'hA2); tick();
    drive4(1'b1, 1'b1, 8'hA3); tick();
    chk("part.drop",  {31'h0, if4.o_drop}, 32'h1);
    chk("part.valid", {31'h0, if4.o_valid}, 32'h0);
    chk("part.cnt",   {28'h0, if4.o_vec_cnt}, 32'h0);
    chk4("part.data", 8'h00, 8'h00, 8'h00, 8'h00);
    drive4(1'b0, 1'b0, 8'h00); tick();
    chk("part.drop_end", {31'h0, if4.o_drop}, 32'h0);
    for (int j = 0; j < 4; j++) begin
      drive4(1'b1, 1'b0, 8'(8'hB0 + j));
      tick();
      chk($sformatf("after_drop.valid%0d", j), {31'h0, if4.o_valid}, {31'h0, (j == 3)});
    end
    chk("after_drop.cnt", {28'h0, if4.o_vec_cnt}, 32'h1);
    chk4("after_drop.data", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    drive4(1'b0, 1'b0, 8'h00); tick();
    chk("after_drop.pulse_end", {31'h0, if4.o_valid}, 32'h0);
    chk4("after_drop.hold", 8'hB0, 8'hB1, 8'hB2, 8'hB3);

    // en gating mid-vector
    drive4(1'b1, 1'b0, 8'hC0); tick();
    drive4(1'b1, 1'b0, 8'hC1); tick();
    en = 1'b0;
    drive4(1'b1, 1'b0, 8'hEE);
    #1;
    chk("gate.ready4", {31'h0, if4.s_ready}, 32'h0);
    chk("gate.ready2", {31'h0, if2.s_ready}, 32'h0);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("gate.valid%0d", j), {31'h0, if4.o_valid}, 32'h0);
      chk($sformatf("gate.cnt%0d", j), {28'h0, if4.o_vec_cnt}, 32'h1);
    end
    chk4("gate.hold", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    en = 1'b1;
    drive4(1'b1, 1'b0, 8'hC2); tick();
    chk("gate.valid_c2", {31'h0, if4.o_valid}, 32'h0);
    drive4(1'b1, 1'b0, 8'hC3); tick();
    chk("gate.valid_c3", {31'h0, if4.o_valid}, 32'h1);
    chk("gate.cnt_end", {28'h0, if4.o_vec_cnt}, 32'h2);
    chk4("gate.data", 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    drive4(1'b0, 1'b0, 8'h00);

    // asynchronous reset mid-vector on the 2-lane instance
    drive2(1'b1, 1'b0, 8'h99); tick();
    drive2(1'b1, 1'b0, 8'h98);
    #3;
    rst = 1'b0;
    #1;
    chk("arst.valid", {31'h0, if2.o_valid}, 32'h0);
    chk("arst.drop",  {31'h0, if2.o_drop}, 32'h0);
    chk("arst.cnt",   {16'h0, if2.o_vec_cnt}, 32'h0);
    chk("arst.data",  {16'h0, if2.o_data[0], if2.o_data[1]}, 32'h0);
    chk("arst.ready", {31'h0, if2.s_ready}, 32'h1);
    chk("arst.cnt4",  {28'h0, if4.o_vec_cnt}, 32'h0);
    tick();
    chk("arst.held_valid", {31'h0, if2.o_valid}, 32'h0);
    chk("arst.held_data",  {16'h0, if2.o_data[0], if2.o_data[1]}, 32'h0);
    #2;
    rst = 1'b1;
    drive2(1'b1, 1'b0, 8'h01); tick();
    chk("post_rst.valid1", {31'h0, if2.o_valid}, 32'h0);
    drive2(1'b1, 1'b0, 8'h02); tick();
    chk("post_rst.valid2", {31'h0, if2.o_valid}, 32'h1);
    chk("post_rst.data",   {16'h0, if2.o_data[0], if2.o_data[1]}, 32'h0102);
    chk("post_rst.cnt",    {16'h0, if2.o_vec_cnt}, 32'h1);
    drive2(1'b0, 1'b0, 8'h00);

    // back-to-back vectors through a 4-bit counter wrap
    for (int v = 1; v <= 17; v++) begin
      for (int j = 0; j < 4; j++) begin
        drive4(1'b1, 1'b0, 8'(v * 4 + j));
        tick();
        chk($sformatf("wrap.v%0d.valid%0d", v, j), {31'h0, if4.o_valid}, {31'h0, (j == 3)});
      end
      chk($sformatf("wrap.v%0d.cnt", v), {28'h0, if4.o_vec_cnt}, 32'(v % 16));
    end
    chk4("wrap.data17", 8'd68, 8'd69, 8'd70, 8'd71);
    drive4(1'b0, 1'b0, 8'h00); tick();
    chk("wrap.pulse_end", {31'h0, if4.o_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
